// File: rtl/unidade_busca_pkg.sv
// Shared MIPS definitions used by the fetch stage and the control unit:
// fetch FSM encoding, the default reset PC and the opcode constants.
package pkg_mips;

  localparam int          DATA_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  function automatic logic [DATA_W-1:0] pc_plus4(input logic [DATA_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/unidade_busca_if.sv
// Instruction-memory request/response port plus the fetch-to-decode
// valid/ready handshake. The master modport is the fetch stage.
interface unidade_busca_if;
  import pkg_mips::*;

  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_pc;
  logic [DATA_W-1:0] if_pc4;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/unidade_busca_calc_pc.sv
// Redirect decision and target address from the execute-stage Branch/Jump
// signals. Jump has priority over a taken branch.
module calc_pc
  import pkg_mips::*;
(
  input  logic              ex_branch_i,
  input  logic              ex_zero_i,
  input  logic              ex_jump_i,
  input  logic [DATA_W-1:0] ex_pc4_i,
  input  logic [15:0]       ex_imm16_i,
  input  logic [25:0]       ex_jidx_i,
  output logic              redirect_o,
  output logic [DATA_W-1:0] target_o
);

  logic [DATA_W-1:0] br_off_s;

  // Redirect condition and branch/jump target selection
  always_comb begin
    br_off_s   = {{14{ex_imm16_i[15]}}, ex_imm16_i, 2'b00};
    redirect_o = ex_jump_i | (ex_branch_i & ex_zero_i);
    if (ex_jump_i) begin
      target_o = {ex_pc4_i[31:28], ex_jidx_i, 2'b00};
    end else begin
      target_o = ex_pc4_i + br_off_s;
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM and the
// OUT register presented to decode. Wrong-path returns are dropped via kill.
module unidade_busca
  import pkg_mips::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  unidade_busca_if.master        bus,
  input  logic                   ex_branch,
  input  logic                   ex_zero,
  input  logic                   ex_jump,
  input  logic [DATA_W-1:0]      ex_pc4,
  input  logic [15:0]            ex_imm16,
  input  logic [25:0]            ex_jidx
);

  localparam logic [DATA_W-1:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] ipc4_q, ipc4_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              redirect_s;
  logic [DATA_W-1:0] target_s;

  calc_pc u_calc_pc (
    .ex_branch_i (ex_branch),
    .ex_zero_i   (ex_zero),
    .ex_jump_i   (ex_jump),
    .ex_pc4_i    (ex_pc4),
    .ex_imm16_i  (ex_imm16),
    .ex_jidx_i   (ex_jidx),
    .redirect_o  (redirect_s),
    .target_o    (target_s)
  );

  // Next-state, PC and output-register logic of the fetch FSM
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    case (state_q)
      FETCH: begin
        // req_q gates gnt so a grant in the first cycle after reset is not taken
        if (req_q && bus.imem_gnt) begin
          state_d = WAIT;
          if (redirect_s) begin
            pc_d   = target_s;
            kill_d = 1'b1;
          end else begin
            kill_d = 1'b0;
          end
        end else if (redirect_s) begin
          pc_d = target_s;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (kill_q || redirect_s) begin
            kill_d  = 1'b0;
            state_d = FETCH;
            if (redirect_s) begin
              pc_d = target_s;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            instr_d = bus.imem_rdata;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4(pc_q);
            pc_d    = pc_plus4(pc_q);
            state_d = OUT;
          end
        end else if (redirect_s) begin
          pc_d   = target_s;
          kill_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      OUT: begin
        if (redirect_s) begin
          pc_d    = target_s;
          state_d = FETCH;
        end else if (bus.if_ready) begin
          state_d = FETCH;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = FETCH;
        kill_d  = 1'b0;
      end
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == OUT);
  end

  // State, PC and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      kill_q  <= 1'b0;
      instr_q <= 32'h0000_0000;
      ipc_q   <= 32'h0000_0000;
      ipc4_q  <= 32'h0000_0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;
  assign bus.if_pc4    = ipc4_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: table of straight-line fetches with
// varying latency/backpressure, then hand-written redirect and reset sequences.
module tb_unidade_busca;
  import pkg_mips::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          gnt_dly;
    int          rv_dly;
    int          stall;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_branch = 1'b0;
  logic        ex_zero = 1'b0;
  logic        ex_jump = 1'b0;
  logic [31:0] ex_pc4 = 32'h0;
  logic [15:0] ex_imm16 = 16'h0;
  logic [25:0] ex_jidx = 26'h0;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  vec_t vecs[6];

  unidade_busca_if bus ();

  unidade_busca dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ex_branch (ex_branch),
    .ex_zero   (ex_zero),
    .ex_jump   (ex_jump),
    .ex_pc4    (ex_pc4),
    .ex_imm16  (ex_imm16),
    .ex_jidx   (ex_jidx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_ex();
    ex_branch = 1'b0; ex_zero = 1'b0; ex_jump = 1'b0;
    ex_pc4 = 32'h0; ex_imm16 = 16'h0; ex_jidx = 26'h0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req === 1'b1) break;
      tick();
    end
    chk("req_seen", {31'h0, bus.imem_req}, 32'd1);
  endtask

  task automatic wait_valid_pop();
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (bus.if_valid === 1'b1) break;
      tick();
    end
    chk("valid_seen", {31'h0, bus.if_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("if_instr", bus.if_instr, e.instr);
      chk("if_pc", bus.if_pc, e.pc);
      chk("if_pc4", bus.if_pc4, e.pc4);
    end
  endtask

  // Drive one fetch up to the OUT state (handshake not completed)
  task automatic to_out(input logic [31:0] addr, input logic [31:0] data, input int gd, input int rd);
    exp_t e;
    wait_req();
    chk("imem_addr", bus.imem_addr, addr);
    repeat (gd) begin
      bus.imem_gnt = 1'b0;
      tick();
    end
    chk("req_held", {31'h0, bus.imem_req}, 32'd1);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    chk("req_low_wait", {31'h0, bus.imem_req}, 32'd0);
    repeat (rd) tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    e.instr = data; e.pc = addr; e.pc4 = addr + 32'd4;
    sb.push_back(e);
    tick();
    bus.imem_rvalid = 1'b0;
    wait_valid_pop();
  endtask

  task automatic fetch_vec(input vec_t v);
    logic [31:0] held;
    to_out(v.addr, v.data, v.gnt_dly, v.rv_dly);
    held = bus.if_instr;
    for (int s = 0; s < v.stall; s++) begin
      tick();
      chk("stall_valid", {31'h0, bus.if_valid}, 32'd1);
      chk("stall_instr", bus.if_instr, held);
      chk("stall_req", {31'h0, bus.imem_req}, 32'd0);
    end
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    chk("post_ready_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("post_ready_req", {31'h0, bus.imem_req}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0040_0000, {OP_ADDI, 26'h008_0005}, 0, 0, 5};
    vecs[1] = '{32'h0040_0004, {OP_LW,   26'h123_4567}, 2, 0, 0};
    vecs[2] = '{32'h0040_0008, {OP_SW,   26'h3AB_CDEF}, 0, 3, 1};
    vecs[3] = '{32'h0040_000C, {OP_R,    26'h000_0020}, 1, 1, 2};
    vecs[4] = '{32'h0040_0010, {OP_BEQ,  26'h109_FFFC}, 0, 2, 0};
    vecs[5] = '{32'h0040_0014, {OP_J,    26'h010_0000}, 3, 0, 3};

    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0; bus.if_ready = 1'b0;
    #1;
    chk("rst_req", {31'h0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'h0);
    chk("rst_pc", bus.if_pc, 32'h0);
    chk("rst_pc4", bus.if_pc4, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("init_req", {31'h0, bus.imem_req}, 32'd1);
    chk("init_addr", bus.imem_addr, 32'h0040_0000);
    chk("init_valid", {31'h0, bus.if_valid}, 32'd0);

    for (int i = 0; i < 6; i++) fetch_vec(vecs[i]);

    // BEQ taken in OUT together with if_ready: redirect wins
    to_out(32'h0040_0018, 32'h1109_FFFC, 0, 0);
    ex_branch = 1'b1; ex_zero = 1'b1; ex_pc4 = 32'h0040_0010; ex_imm16 = 16'hFFFC;
    bus.if_ready = 1'b1;
    tick();
    clear_ex(); bus.if_ready = 1'b0;
    chk("beq_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("beq_req", {31'h0, bus.imem_req}, 32'd1);
    chk("beq_addr", bus.imem_addr, 32'h0040_0000);

    // Branch not taken in OUT
    to_out(32'h0040_0000, 32'h2008_0005, 0, 0);
    ex_branch = 1'b1; ex_zero = 1'b0; ex_pc4 = 32'h0040_0010; ex_imm16 = 16'hFFFC;
    tick();
    clear_ex();
    chk("bnt_valid", {31'h0, bus.if_valid}, 32'd1);
    chk("bnt_pc", bus.if_pc, 32'h0040_0000);
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    chk("bnt_addr", bus.imem_addr, 32'h0040_0004);

    // Jump while waiting for rvalid: returning word is dropped
    wait_req();
    chk("jw_addr0", bus.imem_addr, 32'h0040_0004);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    ex_jump = 1'b1; ex_pc4 = 32'h0040_0008; ex_jidx = 26'h010_0003;
    tick();
    clear_ex();
    chk("jw_req_wait", {31'h0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("jw_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("jw_req", {31'h0, bus.imem_req}, 32'd1);
    chk("jw_addr", bus.imem_addr, 32'h0040_000C);

    // Redirect with gnt in the same FETCH cycle; Jump beats Branch&Zero
    bus.imem_gnt = 1'b1;
    ex_jump = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
    ex_pc4 = 32'h1000_0004; ex_jidx = 26'h000_0010; ex_imm16 = 16'h0001;
    tick();
    bus.imem_gnt = 1'b0;
    clear_ex();
    chk("kill_req_wait", {31'h0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0001;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("kill_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("kill_addr", bus.imem_addr, 32'h1000_0040);

    // Taken branch in FETCH without gnt
    ex_branch = 1'b1; ex_zero = 1'b1; ex_pc4 = 32'h1000_0044; ex_imm16 = 16'h0003;
    tick();
    clear_ex();
    chk("fr_req", {31'h0, bus.imem_req}, 32'd1);
    chk("fr_addr", bus.imem_addr, 32'h1000_0050);

    // Stray rvalid in FETCH is ignored
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_rvalid = 1'b0;
    tick();
    chk("stray_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("stray_addr", bus.imem_addr, 32'h1000_0050);

    // PC wrap from 0xFFFF_FFFC
    ex_jump = 1'b1; ex_pc4 = 32'hF000_0000; ex_jidx = 26'h3FF_FFFF;
    tick();
    clear_ex();
    fetch_vec('{32'hFFFF_FFFC, 32'h0800_0000, 0, 0, 1});
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Asynchronous reset in the middle of a cycle while in OUT
    to_out(32'h0000_0000, 32'h2008_0005, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("arst_req", {31'h0, bus.imem_req}, 32'd0);
    chk("arst_instr", bus.if_instr, 32'h0);
    chk("arst_pc", bus.if_pc, 32'h0);
    chk("arst_pc4", bus.if_pc4, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("arst_rel_req", {31'h0, bus.imem_req}, 32'd1);
    chk("arst_rel_addr", bus.imem_addr, 32'h0040_0000);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
